// File: rtl/mem_access_unit_pkg.sv
// Shared types and funct3 codes for the data-memory access stage.
// Also holds the legality check applied to each incoming access.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic acc_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok_f3;
    logic ok_al;
    if (wr)
      ok_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      ok_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    ok_al = 1'b1;
    if (f3[1:0] == 2'b01)
      ok_al = ~off[0];
    else if (f3[1:0] == 2'b10)
      ok_al = (off == 2'b00);
    return (rd ^ wr) && ok_f3 && ok_al;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready bus between the access stage and the data-memory wrapper.
// master = access stage, slave = memory wrapper.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_wstrb;
  logic [31:0]       dm_wdata;
  logic              dm_ready;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_write, dm_addr, dm_wstrb, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_write, dm_addr, dm_wstrb, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_st_f3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      F3_H: begin
        o_wstrb = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_data[15:0]}};
      end
      F3_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_ext = 32'h0;
    case (i_ld_f3)
      F3_B:    o_ld_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_ext = {24'h0, w_byte};
      F3_H:    o_ld_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_ext = {16'h0, w_half};
      F3_W:    o_ld_ext = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: single-outstanding request/ready FSM,
// payload registers, load write-back register and pipeline stall.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  mem_access_unit_if.master dm,
  output logic              lsu_stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              access_err
);

  state_e            r_state;
  logic              r_req;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_ld_data;
  logic              r_ld_valid;
  logic              r_err;

  logic              w_present;
  logic              w_legal;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_ext;

  assign w_present = mem_read | mem_write;
  assign w_legal   = acc_legal(mem_read, mem_write, funct3, addr[1:0]);

  mem_lane_align u_align (
    .i_st_f3   (funct3),
    .i_st_off  (addr[1:0]),
    .i_st_data (store_data),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .i_ld_f3   (r_f3),
    .i_ld_off  (r_off),
    .i_rdata   (dm.dm_rdata),
    .o_ld_ext  (w_ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= 32'h0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      r_ld_data  <= 32'h0;
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_present && w_legal) begin
            r_req   <= 1'b1;
            r_write <= mem_write;
            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_wstrb <= mem_write ? w_wstrb : 4'b0000;
            r_wdata <= mem_write ? w_wdata : 32'h0;
            r_f3    <= funct3;
            r_off   <= addr[1:0];
            r_state <= BUSY;
          end else if (w_present) begin
            r_err <= 1'b1;
          end
        end
        BUSY: begin
          if (dm.dm_ready) begin
            r_req <= 1'b0;
            if (!r_write) begin
              r_ld_data  <= w_ld_ext;
              r_ld_valid <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        // EXE/MEM still shows the finished access here; ignore it.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_stall   = ((r_state == IDLE) && w_present && w_legal) ||
                       (r_state == BUSY);
  assign dm.dm_req   = r_req;
  assign dm.dm_write = r_write;
  assign dm.dm_addr  = r_addr;
  assign dm.dm_wstrb = r_wstrb;
  assign dm.dm_wdata = r_wdata;
  assign ld_data     = r_ld_data;
  assign ld_valid    = r_ld_valid;
  assign access_err  = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with an
// arithmetic reference model of legality, steering and extension.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        lsu_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        access_err;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) dm ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dm         (dm),
    .lsu_stall  (lsu_stall),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .access_err (access_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    if (f3[1:0] == 2'd2) return 4;
    return 0;
  endfunction

  function automatic bit legal_m(input bit rd, input bit wr,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    int n;
    bit f3ok;
    if (rd == wr) return 0;
    if (wr) f3ok = (f3 <= 3'd2);
    else    f3ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!f3ok) return 0;
    n = size_of(f3);
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3,
                                         input logic [31:0] a);
    int n = size_of(f3);
    int s = ((1 << n) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    int n = size_of(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    int n = size_of(f3);
    logic [31:0] v = w >> (8 * (a % 4));
    bit sgn = (f3 == 3'd0) || (f3 == 3'd1);
    if (n == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Called one time unit after a rising edge; returns in the same phase.
  task automatic run_acc(input bit rd, input bit wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] word,
                         input int wt);
    bit ok;
    int stalls;
    ok = legal_m(rd, wr, f3, a);
    mem_read    = rd;
    mem_write   = wr;
    funct3      = f3;
    addr        = a;
    store_data  = d;
    dm.dm_ready = 1'b0;
    dm.dm_rdata = word;
    #1;
    stalls = int'(lsu_stall);
    chk("stall_c0", {31'b0, lsu_stall}, {31'b0, ok});
    if (!ok) begin
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      chk("err_pulse", {31'b0, access_err}, 32'd1);
      chk("err_no_req", {31'b0, dm.dm_req}, 32'd0);
      chk("err_no_stall", {31'b0, lsu_stall}, 32'd0);
      chk("err_no_ldv", {31'b0, ld_valid}, 32'd0);
      @(posedge clk); #1;
      chk("err_once", {31'b0, access_err}, 32'd0);
      chk("err_ld_hold", ld_data, last_ld);
    end else begin
      for (int k = 1; k <= wt + 1; k++) begin
        @(posedge clk); #1;
        dm.dm_ready = (k == wt + 1);
        #1;
        stalls += int'(lsu_stall);
        chk("busy_req", {31'b0, dm.dm_req}, 32'd1);
        chk("busy_write", {31'b0, dm.dm_write}, {31'b0, wr});
        chk("busy_addr", dm.dm_addr, a & 32'hFFFF_FFFC);
        chk("busy_wstrb", {28'b0, dm.dm_wstrb},
            {28'b0, wr ? m_wstrb(f3, a) : 4'b0000});
        if (wr) chk("busy_wdata", dm.dm_wdata, m_wdata(f3, d));
        chk("busy_ldv", {31'b0, ld_valid}, 32'd0);
      end
      @(posedge clk); #1;
      dm.dm_ready = 1'b0;
      #1;
      if (rd) last_ld = m_load(f3, a, word);
      chk("resp_req", {31'b0, dm.dm_req}, 32'd0);
      chk("resp_stall", {31'b0, lsu_stall}, 32'd0);
      chk("resp_ldv", {31'b0, ld_valid}, {31'b0, rd});
      chk("resp_ld_data", ld_data, last_ld);
      chk("stall_cycles", stalls, 2 + wt);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      chk("after_ldv", {31'b0, ld_valid}, 32'd0);
      chk("after_req", {31'b0, dm.dm_req}, 32'd0);
      chk("after_err", {31'b0, access_err}, 32'd0);
      chk("after_ld_hold", ld_data, last_ld);
    end
  endtask

  initial begin
    bit          rd;
    bit          wr;
    logic [31:0] a;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    store_data  = 32'h0;
    dm.dm_ready = 1'b0;
    dm.dm_rdata = 32'h0;
    #1;
    chk("rst_req", {31'b0, dm.dm_req}, 32'd0);
    chk("rst_wstrb", {28'b0, dm.dm_wstrb}, 32'd0);
    chk("rst_wdata", dm.dm_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_flags", {29'b0, ld_valid, access_err, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_acc(0, 1, F3_W,  32'h1004, 32'hDEADBEEF, 32'h0, 0);
    run_acc(0, 1, F3_B,  32'h1003, 32'h000000A5, 32'h0, 0);
    run_acc(1, 0, F3_B,  32'h2002, 32'h0, 32'h80FF7F01, 0);
    run_acc(1, 0, F3_BU, 32'h2003, 32'h0, 32'h80FF7F01, 1);
    run_acc(1, 0, F3_H,  32'h2000, 32'h0, 32'h80FF7F01, 0);
    run_acc(1, 0, F3_W,  32'h2008, 32'h0, 32'h12345678, 3);
    run_acc(1, 0, F3_H,  32'h3001, 32'h0, 32'h0, 0);
    run_acc(1, 1, F3_W,  32'h3000, 32'h0, 32'h0, 0);

    dm.dm_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_ignored", {31'b0, dm.dm_req}, 32'd0);
    dm.dm_ready = 1'b0;

    mem_read = 1'b1;
    funct3   = F3_W;
    addr     = 32'h40;
    @(posedge clk); #1;
    chk("mid_busy_req", {31'b0, dm.dm_req}, 32'd1);
    #2;
    rst      = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, dm.dm_req}, 32'd0);
    chk("mid_rst_addr", dm.dm_addr, 32'd0);
    chk("mid_rst_ld", ld_data, 32'd0);
    chk("mid_rst_flags", {29'b0, ld_valid, access_err, lsu_stall}, 32'd0);
    last_ld = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_acc(0, 1, F3_W, 32'h1008, 32'hCAFEF00D, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_acc(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage for the five-stage RV32I core. Consumes the execute stage's load/store outputs (address from the ALU, forwarded store data, funct3, MemRead/MemWrite), issues a single-outstanding request/ready transaction toward the data-memory wrapper, and stalls the pipeline until the access completes. It performs byte-lane steering and write-strobe generation for stores. For loads it performs lane extraction plus sign or zero extension, and returns a ready-to-write-back value.

## Interface
- ADDR_W, 32, data-memory byte address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  load in the EXE/MEM register
- mem_write  in  1  store in the EXE/MEM register
- funct3  in  3  access size/sign (RV32I load/store encoding)
- addr  in  ADDR_W  byte address (ALU result)
- store_data  in  32  forwarded rs2 value
- dm_req  out  1  request valid toward the memory wrapper
- dm_write  out  1  1 = store, 0 = load
- dm_addr  out  ADDR_W  word-aligned address, with addr[1:0] forced to 0
- dm_wstrb  out  4  byte write enables; 0000 on loads
- dm_wdata  out  32  lane-steered store data
- dm_ready  in  1  transaction complete; dm_rdata is valid on loads
- dm_rdata  in  32  raw read word
- lsu_stall  out  1  hold IF..MEM stages
- ld_data  out  32  extended load result
- ld_valid  out  1  one-cycle pulse: ld_data valid for write-back
- access_err  out  1  one-cycle pulse: access rejected

## Operation
- The state machine has three states: IDLE, BUSY and RESP.
- **IDLE**
  - An access is present when mem_read or mem_write is high.
  - The access is legal when both of the following hold:
    - Exactly one of mem_read and mem_write is high.
    - funct3 is valid for the operation and the address is aligned:
      - loads: funct3 ∈ {000, 001, 010, 100, 101}
      - stores: funct3 ∈ {000, 001, 010}
      - halfword requires addr[0] = 0; word requires addr[1:0] = 00
  - On a legal access:
    - Latch the dm_* payload, funct3 and addr[1:0].
    - Set dm_req to 1 and go to BUSY.
  - On an illegal access:
    - Pulse access_err in the next cycle.
    - Issue no request and stay in IDLE.
    - Do not stall; the instruction retires, and a load produces no ld_valid.
- **BUSY**
  - dm_req stays at 1 and the entire payload stays stable.
  - When dm_ready = 1:
    - Clear dm_req.
    - For a load, register the extended value into ld_data.
    - Go to RESP.
- **RESP**
  - For a load, ld_valid = 1 for this single cycle.
  - Go to IDLE unconditionally. The EXE/MEM inputs still describe the completed access during this cycle and must be ignored.
- lsu_stall is combinational and equals (IDLE and access present and legal) or BUSY. It is 0 in RESP.
- **Stores**
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated to all four lanes.
  - SH: wstrb = 0011 << addr[1:0]; wdata = halfword replicated to both halves.
  - SW: wstrb = 1111; wdata = store_data.
- **Loads**
  - Select the byte or halfword lane of dm_rdata using the latched addr[1:0].
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes the word through.
- ld_data holds its value until the next load completes.

## Timing
- Reset values are 0 for dm_req, dm_write, dm_addr, dm_wstrb, dm_wdata, ld_data, ld_valid and access_err; the state resets to IDLE.
- Asserting reset mid-transaction drops dm_req immediately, asynchronously. The memory wrapper discards any in-flight access.
- Latency, with cycle 0 being the cycle the access appears:
  - dm_req rises at cycle 1.
  - If dm_ready is high in cycle 1, RESP and ld_valid occur in cycle 2.
  - Minimum is therefore 2 stall cycles; each extra wait cycle on dm_ready adds 1.
- dm_ready is sampled only in BUSY. dm_ready in IDLE or RESP is ignored.
- Only one transaction is outstanding at a time; there is no pipelining of requests.
- access_err and ld_valid are registered, exactly one cycle wide, and never asserted in the same cycle.

## Structure
- Shared package mem_access_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - funct3 localparams: F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101
- Sub-module mem_lane_align is purely combinational:
  - store steering: funct3 + addr[1:0] + data → wstrb and wdata
  - load extraction: funct3 + addr[1:0] + rdata → extended value
- The top level holds the FSM, the payload registers and the stall logic.

## Test plan
- **SW:** inputs are SW, addr = 0x1004, data = 0xDEADBEEF.
  - Expect dm_addr = 0x1004, wstrb = 1111, wdata = 0xDEADBEEF.
  - Expect lsu_stall high for 2 cycles with dm_ready returned immediately.
- **SB:** inputs are SB, addr = 0x1003, data = 0x000000A5.
  - Expect dm_addr = 0x1000, wstrb = 1000, wdata = 0xA5A5A5A5.
- **Signed and unsigned byte loads:** dm_rdata = 0x80FF7F01.
  - LB at 0x2002 → ld_data = 0xFFFFFFFF.
  - LBU at 0x2003 → ld_data = 0x00000080.
  - LH at 0x2000 → ld_data = 0x00007F01.
  - In every case ld_valid pulses once.
- **Wait states:** LW with dm_ready delayed 3 cycles.
  - dm_req is held and the payload stays stable for 4 cycles.
  - lsu_stall stays high for 5 cycles.
  - ld_valid follows dm_ready by 1 cycle.
- **Misaligned access:** LH at 0x3001.
  - Expect no dm_req, no stall, and access_err pulsing 1 cycle later.
  - Also drive mem_read = mem_write = 1 → access_err pulses.
- **Reset mid-transaction:** assert rst during BUSY.
  - dm_req falls asynchronously and all outputs go to 0.
  - After reset is released, a new SW completes normally.
